// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen size, ball FSM states and the direction
// encoding that the ball and paddles agree on.
package pong_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {SERVE, PLAY, HOLD, GAME_OVER} state_t;

  localparam logic LEFT  = 1'b1;
  localparam logic RIGHT = 1'b0;
endpackage

// File: rtl/ball_score_keeper.sv
// Saturating scores, win detect and the post-goal freeze counter.
// side names the player who conceded; the opponent's score advances.
module ball_score_keeper
  import pong_pkg::*;
#(
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal,
  input  logic       side,
  input  logic       clear,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       win,
  output logic       hold_done
);
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  logic [CW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_left  <= '0;
      score_right <= '0;
      hold_cnt    <= '0;
    end else begin
      if (clear) begin
        score_left  <= '0;
        score_right <= '0;
      end else if (goal) begin
        if (side == LEFT && score_right < WIN) score_right <= score_right + 4'd1;
        if (side == RIGHT && score_left < WIN) score_left <= score_left + 4'd1;
      end
      if (goal) hold_cnt <= CW'(HOLD_FRAMES - 1);
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
    end
  end

  assign win       = (score_left == WIN) || (score_right == WIN);
  assign hold_done = (hold_cnt == '0);
endmodule

// File: rtl/ball_ctrl.sv
// Pong ball: motion, wall/paddle bounces, goals and serve/game-over flow.
// All geometry compares run in 11 bits with subtractions moved across.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = pong_pkg::SCREEN_W,
  parameter int SCREEN_H    = pong_pkg::SCREEN_H,
  parameter int DX          = 4,
  parameter int DY          = 2,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] wall_width,
  input  logic [5:0] ball_width,
  input  logic [5:0] paddle_width,
  input  logic [8:0] paddle_length,
  input  logic [8:0] left_y,
  input  logic [8:0] right_y,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_direction,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       hit,
  output logic       goal,
  output logic       game_over
);
  state_t      state;
  logic [9:0]  bx;
  logic [8:0]  by;
  logic        ydir_up;
  logic        bdir;

  logic [10:0] x, y, ww, bw, pw, pl, ly, ry, sw, sh, dx, dy;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic        ov_l, ov_r, hit_l, hit_r, goal_l, goal_r, top_wall, bot_wall;
  logic        goal_now, clear, win, hold_done;

  assign x  = 11'(bx);
  assign y  = 11'(by);
  assign ww = 11'(wall_width);
  assign bw = 11'(ball_width);
  assign pw = 11'(paddle_width);
  assign pl = 11'(paddle_length);
  assign ly = 11'(left_y);
  assign ry = 11'(right_y);
  assign sw = 11'(SCREEN_W);
  assign sh = 11'(SCREEN_H);
  assign dx = 11'(DX);
  assign dy = 11'(DY);

  assign cx = 10'((sw - bw) >> 1);
  assign cy = 9'((sh - bw) >> 1);

  assign ov_l     = (y + bw > ly) && (y < ly + pl);
  assign ov_r     = (y + bw > ry) && (y < ry + pl);
  assign hit_l    = (bdir == LEFT) && (x < pw + dx) && ov_l;
  assign goal_l   = (bdir == LEFT) && !hit_l && (x <= dx);
  assign hit_r    = (bdir == RIGHT) && (x + bw + dx + pw > sw) && ov_r;
  assign goal_r   = (bdir == RIGHT) && !hit_r && (x + bw + dx >= sw);
  assign top_wall = y < ww + dy;
  assign bot_wall = y + bw + dy + ww > sh;

  assign goal_now = (state == PLAY) && (goal_l || goal_r);
  assign clear    = (state == GAME_OVER) && serve;

  // Outside PLAY/HOLD the ball is shown centred, so reset recentres it at once.
  assign ball_x         = (state == PLAY || state == HOLD) ? bx : cx;
  assign ball_y         = (state == PLAY || state == HOLD) ? by : cy;
  assign ball_direction = bdir;

  ball_score_keeper #(.HOLD_FRAMES(HOLD_FRAMES), .WIN_SCORE(WIN_SCORE)) u_score (
    .clk         (clk),
    .reset       (reset),
    .goal        (goal_now),
    .side        (bdir),
    .clear       (clear),
    .score_left  (score_left),
    .score_right (score_right),
    .win         (win),
    .hold_done   (hold_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SERVE;
      bx        <= '0;
      by        <= '0;
      ydir_up   <= 1'b1;
      bdir      <= LEFT;
      hit       <= 1'b0;
      goal      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit  <= 1'b0;
      goal <= 1'b0;
      case (state)
        SERVE: if (serve) begin
          state <= PLAY;
          bx    <= cx;
          by    <= cy;
        end
        PLAY: if (goal_l || goal_r) begin
          goal  <= 1'b1;
          state <= HOLD;
        end else begin
          if (hit_l) begin
            bx   <= 10'(pw);
            bdir <= RIGHT;
            hit  <= 1'b1;
          end else if (hit_r) begin
            bx   <= 10'(sw - pw - bw);
            bdir <= LEFT;
            hit  <= 1'b1;
          end else if (bdir == LEFT) bx <= bx - 10'(DX);
          else bx <= bx + 10'(DX);
          if (ydir_up) begin
            if (top_wall) begin
              by      <= 9'(ww);
              ydir_up <= 1'b0;
            end else by <= by - 9'(DY);
          end else begin
            if (bot_wall) begin
              by      <= 9'(sh - ww - bw);
              ydir_up <= 1'b1;
            end else by <= by + 9'(DY);
          end
        end
        // bdir already points at the conceding side, so it is left as is.
        HOLD: if (hold_done) begin
          state     <= win ? GAME_OVER : SERVE;
          game_over <= win;
          ydir_up   <= 1'b1;
        end
        GAME_OVER: if (serve) begin
          state     <= SERVE;
          game_over <= 1'b0;
          ydir_up   <= 1'b1;
        end
        default: state <= SERVE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_ctrl.sv
// Directed Pong scenarios plus randomized play against a frame-level model.
module tb_ball_ctrl;
  localparam int W = 640, H = 480, DX = 4, DY = 2, HF = 60, WIN = 9;

  logic       clk = 1'b0, reset = 1'b0, serve = 1'b0;
  logic [5:0] wall_width, ball_width, paddle_width;
  logic [8:0] paddle_length, left_y, right_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_direction, hit, goal, game_over;
  logic [3:0] score_left, score_right;

  ball_ctrl dut (
    .clk(clk), .reset(reset), .wall_width(wall_width), .ball_width(ball_width),
    .paddle_width(paddle_width), .paddle_length(paddle_length), .left_y(left_y),
    .right_y(right_y), .serve(serve), .ball_x(ball_x), .ball_y(ball_y),
    .ball_direction(ball_direction), .score_left(score_left), .score_right(score_right),
    .hit(hit), .goal(goal), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic ltrk = 1'b0, rtrk = 1'b0;

  // Model: phase 0=serve 1=play 2=hold 3=over; dir 1=left; up 1=up.
  int m_st, mx, my, mdir, mup, msl, msr, mhold, mhit, mgoal, mgo, mconc;

  function automatic int ex();
    return (m_st == 1 || m_st == 2) ? mx : (W - int'(ball_width)) / 2;
  endfunction
  function automatic int ey();
    return (m_st == 1 || m_st == 2) ? my : (H - int'(ball_width)) / 2;
  endfunction

  task automatic model_reset();
    m_st = 0; mdir = 1; mup = 1; msl = 0; msr = 0;
    mhold = 0; mhit = 0; mgoal = 0; mgo = 0; mconc = 1;
  endtask

  task automatic model_step();
    int ww, bw, pw, pl, ly, ry, scored;
    ww = int'(wall_width); bw = int'(ball_width); pw = int'(paddle_width);
    pl = int'(paddle_length); ly = int'(left_y); ry = int'(right_y);
    mhit = 0; mgoal = 0; scored = 0;
    case (m_st)
      0: begin
        mup = 1;
        if (serve) begin m_st = 1; mx = (W - bw) / 2; my = (H - bw) / 2; end
      end
      1: begin
        if (mdir == 1) begin
          if (mx < pw + DX && my + bw > ly && my < ly + pl) begin mx = pw; mdir = 0; mhit = 1; end
          else if (mx <= DX) begin scored = 1; mconc = 1; if (msr < WIN) msr++; end
          else mx -= DX;
        end else begin
          if (mx + bw + DX > W - pw && my + bw > ry && my < ry + pl) begin
            mx = W - pw - bw; mdir = 1; mhit = 1;
          end else if (mx + bw + DX >= W) begin scored = 1; mconc = 0; if (msl < WIN) msl++; end
          else mx += DX;
        end
        if (scored != 0) begin mgoal = 1; m_st = 2; mhold = HF; end
        else if (mup == 1) begin
          if (my - DY < ww) begin my = ww; mup = 0; end else my -= DY;
        end else begin
          if (my + bw + DY > H - ww) begin my = H - ww - bw; mup = 1; end else my += DY;
        end
      end
      2: begin
        mhold--;
        if (mhold == 0) begin
          mdir = mconc;
          if (msl == WIN || msr == WIN) begin m_st = 3; mgo = 1; end else m_st = 0;
        end
      end
      default: if (serve) begin msl = 0; msr = 0; mgo = 0; m_st = 0; end
    endcase
  endtask

  task automatic track();
    if (ltrk) left_y = 9'(ey() >= 28 ? ey() - 28 : 0);
    if (rtrk) right_y = 9'(ey() >= 28 ? ey() - 28 : 0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    track();
  endtask

  task automatic test_reset();
    wall_width = 6'd8; ball_width = 6'd8; paddle_width = 6'd8; paddle_length = 9'd64;
    left_y = 9'd200; right_y = 9'd200; serve = 1'b0; reset = 1'b0;
    model_reset();
    #23 reset = 1'b1;
    repeat (10) step();
    n_chk++; if ({ball_x, ball_y} !== {10'd316, 9'd236}) begin
      n_fail++; $display("FAIL reset_pos act=%0d,%0d exp=316,236", ball_x, ball_y); end
    n_chk++; if (ball_direction !== 1'b1) begin
      n_fail++; $display("FAIL reset_dir act=%0d exp=1", ball_direction); end
    n_chk++; if ({score_left, score_right, hit, goal, game_over} !== 11'd0) begin
      n_fail++; $display("FAIL reset_flags act=%0d,%0d,%b%b%b exp=0,0,000",
                         score_left, score_right, hit, goal, game_over); end
  endtask

  task automatic test_left_hit();
    ltrk = 1'b1; rtrk = 1'b1; track();
    serve = 1'b1; step(); serve = 1'b0;
    for (int e = 316; e >= 8; e -= 4) begin
      n_chk++; if (ball_x !== 10'(e) || hit !== 1'b0) begin
        n_fail++; $display("FAIL lhit_approach act=%0d hit=%b exp=%0d hit=0", ball_x, hit, e); end
      step();
    end
    n_chk++; if ({hit, ball_direction, ball_x} !== {1'b1, 1'b0, 10'd8}) begin
      n_fail++; $display("FAIL lhit_bounce act=hit%b dir%b x%0d exp=hit1 dir0 x8", hit, ball_direction, ball_x); end
    step();
    n_chk++; if ({hit, ball_x} !== {1'b0, 10'd12}) begin
      n_fail++; $display("FAIL lhit_after act=hit%b x%0d exp=hit0 x12", hit, ball_x); end
  endtask

  task automatic test_top_wall();
    int k = 0;
    int seq[6] = '{8, 8, 10, 12, 14, 16};
    while (ball_y !== 9'd10 && k < 200) begin step(); k++; end
    n_chk++; if (k >= 200) begin n_fail++; $display("FAIL top_timeout act=%0d exp=10", ball_y); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++; if (ball_y !== 9'(seq[i])) begin
        n_fail++; $display("FAIL top_seq%0d act=%0d exp=%0d", i, ball_y, seq[i]); end
    end
  endtask

  task automatic test_right();
    int k = 0;
    while (ball_x !== 10'd624 && k < 300) begin step(); k++; end
    n_chk++; if (k >= 300 || hit !== 1'b0 || ball_direction !== 1'b0) begin
      n_fail++; $display("FAIL rhit_reach act=x%0d hit%b dir%b exp=x624 hit0 dir0", ball_x, hit, ball_direction); end
    step();
    n_chk++; if ({hit, ball_direction, ball_x} !== {1'b1, 1'b1, 10'd624}) begin
      n_fail++; $display("FAIL rhit_bounce act=hit%b dir%b x%0d exp=hit1 dir1 x624", hit, ball_direction, ball_x); end
    step();
    n_chk++; if (ball_x !== 10'd620) begin
      n_fail++; $display("FAIL rhit_after act=%0d exp=620", ball_x); end
    k = 0;
    while (ball_direction !== 1'b0 && k < 300) begin step(); k++; end
    rtrk = 1'b0; right_y = 9'd400;
    k = 0;
    while (goal !== 1'b1 && k < 3000) begin step(); k++; end
    n_chk++; if (k >= 3000 || ball_x !== 10'd628) begin
      n_fail++; $display("FAIL rmiss_goal act=x%0d goal%b exp=x628 goal1", ball_x, goal); end
    n_chk++; if ({score_left, score_right} !== {4'd1, 4'd0}) begin
      n_fail++; $display("FAIL rmiss_score act=%0d,%0d exp=1,0", score_left, score_right); end
  endtask

  task automatic test_miss();
    int k = 0;
    reset = 1'b0; model_reset(); ltrk = 1'b0; left_y = 9'd400; rtrk = 1'b1;
    #3 reset = 1'b1;
    serve = 1'b1; step(); serve = 1'b0;
    while (goal !== 1'b1 && k < 200) begin step(); k++; end
    n_chk++; if (k >= 200 || ball_x !== 10'd4) begin
      n_fail++; $display("FAIL miss_goal act=x%0d goal%b exp=x4 goal1", ball_x, goal); end
    n_chk++; if ({score_left, score_right} !== {4'd0, 4'd1}) begin
      n_fail++; $display("FAIL miss_score act=%0d,%0d exp=0,1", score_left, score_right); end
    for (int i = 0; i < 60; i++) begin
      n_chk++; if (ball_x !== 10'd4 || goal !== (i == 0)) begin
        n_fail++; $display("FAIL miss_hold%0d act=x%0d goal%b exp=x4 goal%0d", i, ball_x, goal, i == 0); end
      serve = (i < 50);
      step();
    end
    serve = 1'b0;
    n_chk++; if ({ball_x, ball_y, ball_direction} !== {10'd316, 9'd236, 1'b1}) begin
      n_fail++; $display("FAIL miss_recentre act=%0d,%0d dir%b exp=316,236 dir1", ball_x, ball_y, ball_direction); end
    repeat (5) step();
    n_chk++; if (ball_x !== 10'd316) begin
      n_fail++; $display("FAIL miss_wait act=%0d exp=316", ball_x); end
  endtask

  task automatic test_reset_mid_play();
    serve = 1'b1; step(); serve = 1'b0;
    repeat (15) step();
    #2 reset = 1'b0; model_reset();
    #1;
    n_chk++; if ({ball_x, ball_y, ball_direction} !== {10'd316, 9'd236, 1'b1}) begin
      n_fail++; $display("FAIL midrst_pos act=%0d,%0d dir%b exp=316,236 dir1", ball_x, ball_y, ball_direction); end
    n_chk++; if ({score_left, score_right, hit, goal, game_over} !== 11'd0) begin
      n_fail++; $display("FAIL midrst_flags act=%0d,%0d,%b%b%b exp=0,0,000",
                         score_left, score_right, hit, goal, game_over); end
    #2 reset = 1'b1;
  endtask

  task automatic test_game_over();
    ltrk = 1'b0; left_y = 9'd400;
    for (int g = 1; g <= 9; g++) begin
      int k = 0;
      serve = 1'b1; step(); serve = 1'b0;
      while (goal !== 1'b1 && k < 200) begin step(); k++; end
      n_chk++; if (k >= 200 || score_right !== 4'(g)) begin
        n_fail++; $display("FAIL go_score%0d act=%0d exp=%0d", g, score_right, g); end
      repeat (60) step();
      n_chk++; if (game_over !== (g == 9)) begin
        n_fail++; $display("FAIL go_flag%0d act=%b exp=%0d", g, game_over, g == 9); end
    end
    repeat (5) step();
    n_chk++; if ({game_over, score_left, score_right, ball_x} !== {1'b1, 4'd0, 4'd9, 10'd316}) begin
      n_fail++; $display("FAIL go_held act=go%b %0d,%0d x%0d exp=go1 0,9 x316", game_over, score_left, score_right, ball_x); end
    serve = 1'b1; step(); serve = 1'b0;
    n_chk++; if ({game_over, score_left, score_right} !== 9'd0) begin
      n_fail++; $display("FAIL go_clear act=go%b %0d,%0d exp=go0 0,0", game_over, score_left, score_right); end
    repeat (3) step();
    n_chk++; if (ball_x !== 10'd316) begin
      n_fail++; $display("FAIL go_serve_wait act=%0d exp=316", ball_x); end
  endtask

  task automatic test_random();
    logic [30:0] act, exp;
    int t;
    ltrk = 1'b0; rtrk = 1'b0;
    for (int r = 0; r < 3; r++) begin
      reset = 1'b0; model_reset();
      wall_width = 6'($urandom_range(2, 30)); ball_width = 6'($urandom_range(2, 30));
      paddle_width = 6'($urandom_range(2, 30)); paddle_length = 9'($urandom_range(10, 200));
      #3 reset = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        serve = ($urandom_range(0, 7) == 0);
        t = ey() - int'($urandom_range(0, int'(paddle_length))); if (t < 0) t = 0;
        left_y = ($urandom_range(0, 3) != 0) ? 9'(t) : 9'($urandom_range(0, 479));
        t = ey() - int'($urandom_range(0, int'(paddle_length))); if (t < 0) t = 0;
        right_y = ($urandom_range(0, 3) != 0) ? 9'(t) : 9'($urandom_range(0, 479));
        step();
        act = {ball_x, ball_y, ball_direction, score_left, score_right, hit, goal, game_over};
        exp = {10'(ex()), 9'(ey()), mdir[0], 4'(msl), 4'(msr), mhit[0], mgoal[0], mgo[0]};
        n_chk++; if (act !== exp) begin
          n_fail++; $display("FAIL rand r%0d c%0d act=%h exp=%h", r, c, act, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_hit();
    test_top_wall();
    test_right();
    test_miss();
    test_reset_mid_play();
    test_game_over();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
